sa_scheduler: RTL

SA_SCHEDULER -- requirements
Module: sa_scheduler

---
 rtl/sa_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sa_scheduler.sv
// sa_scheduler: sequences one matrix job through an N x N systolic array.
// A job clears the PE accumulators, feeds skewed operand indices for
// k_len + 2(N-1) cycles, then drains the N result rows under out_ready
// handshake. Every output is a flop loaded from next-state decode, so no
// input reaches an output without passing through a register.
module sa_scheduler #(
  parameter int N     = 4,
  parameter int K_MAX = 64,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CW-1:0]          k_len,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   pe_clr,
  output logic [CW-1:0]          feed_cnt,
  output logic [N-1:0]           lane_valid,
  output logic [N*CW-1:0]        lane_k,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   out_row,
  output logic                   done,
  output logic                   err
);

  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] KMAX_C    = CW'(K_MAX);
  // Last feed cycle is k_len + 2(N-1) - 1.
  localparam logic [CW-1:0] SKEW_LAST = CW'(2 * N - 3);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   k_lat, k_d;
  logic [CW-1:0]   feed_d;
  logic [RW-1:0]   row_d;
  logic            clr_d;
  logic            err_d;
  logic [N-1:0]    lane_valid_d;
  logic [N*CW-1:0] lane_k_d;
  logic [CW-1:0]   feed_last;

  assign feed_last = k_lat + SKEW_LAST;

  // Next-state and next-output decode; feed_cnt/out_row double as counters.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    state_d = state;
    k_d     = k_lat;
    feed_d  = '0;
    row_d   = '0;
    clr_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0 && k_len <= KMAX_C) begin
            k_d     = k_len;
            clr_d   = 1'b1;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (feed_cnt == feed_last) state_d = S_DRAIN;
        else                       feed_d  = feed_cnt + CW'(1);
      end
      S_DRAIN: begin
        if (!out_ready)               row_d   = out_row;
        else if (out_row == ROW_LAST) state_d = S_DONE;
        else                          row_d   = out_row + RW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every in-job transition and clears the partial sums.
    if (abort && (state == S_CLEAR || state == S_FEED || state == S_DRAIN)) begin
      state_d = S_IDLE;
      clr_d   = 1'b1;
      feed_d  = '0;
      row_d   = '0;
    end
  end

  // Lane skew: lane i starts i cycles late and stays valid for k_len cycles.
  always_comb begin
    lane_valid_d = '0;
    lane_k_d     = '0;
    for (int i = 0; i < N; i++) begin
      if (state_d == S_FEED && feed_d >= CW'(i) && feed_d < CW'(i) + k_d) begin
        lane_valid_d[i]         = 1'b1;
        lane_k_d[i*CW +: CW]    = feed_d - CW'(i);
      end
    end
  end

  // State, latched job length and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      k_lat      <= '0;
      busy       <= 1'b0;
      pe_clr     <= 1'b0;
      feed_cnt   <= '0;
      lane_valid <= '0;
      lane_k     <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, matching real register behaviour.
      state      <= state_d;
      k_lat      <= k_d;
      busy       <= (state_d != S_IDLE);
      pe_clr     <= clr_d;
      feed_cnt   <= feed_d;
      lane_valid <= lane_valid_d;
      lane_k     <= lane_k_d;
      out_valid  <= (state_d == S_DRAIN);
      out_row    <= row_d;
      done       <= (state_d == S_DONE);
      err        <= err_d;
    end
  end

endmodule
